ads7883_emulator: RTL and testbench



---
 rtl/ads7883_emulator.sv | 183 ++++++++++++++++++
 tb/tb_ads7883_emulator.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ads7883_emulator.sv
// Serial-ADC slave emulator: replays a 12-bit conversion word on SDO, framed by CONVST and clocked by SCLK.
// Define ADC_EMU_RAMP_EN to replace sample_in with an internal 12-bit ramp that advances once per completed frame.
module ads7883_emulator #(
    parameter int SYNC_STAGES = 2,  // 2..4
    parameter int LEAD_ZEROS  = 2   // 1..240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CONVST,
    input  logic        SCLK,
    input  logic [11:0] sample_in,
    output logic        SDO,
    output logic        SDO_OE,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        DATA  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    localparam logic [7:0] LZ_CNT   = 8'(LEAD_ZEROS);
    localparam logic [7:0] LAST_CNT = 8'(LEAD_ZEROS + 12);
    localparam logic [2:0] SETTLE   = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic                   cs_prev_q;
    logic                   sclk_prev_q;
    logic                   cs_s;
    logic                   sclk_s;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   sclk_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '1;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b1;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CONVST};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
        end
    end

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;

    // The synchronizers reset to 1, so a CONVST held low through reset would look like a
    // falling edge once flushed; frames are only armed after CONVST is seen high post-reset.
    logic [2:0] settle_q;
    logic       armed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            settle_q <= 3'd0;
            armed_q  <= 1'b0;
        end else if (settle_q != SETTLE) begin
            settle_q <= settle_q + 3'd1;
        end else if (cs_s) begin
            armed_q <= 1'b1;
        end
    end

    state_t      state_q, state_n;
    logic [11:0] shreg_q, shreg_n;
    logic [7:0]  bit_cnt_q, bit_cnt_n;
    logic [7:0]  cnt_inc;
    logic        sdo_q, sdo_n;
    logic        done_n;
    logic [15:0] fcnt_n;
    logic [11:0] capture_val;

`ifdef ADC_EMU_RAMP_EN
    logic [11:0] ramp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ramp_q <= 12'd0;
        end else if (done_n) begin
            ramp_q <= ramp_q + 12'd1;
        end
    end

    assign capture_val = ramp_q;
`else
    assign capture_val = sample_in;
`endif

    assign cnt_inc = (bit_cnt_q == 8'hFF) ? bit_cnt_q : bit_cnt_q + 8'd1;

    always_comb begin
        state_n   = state_q;
        shreg_n   = shreg_q;
        bit_cnt_n = bit_cnt_q;
        sdo_n     = sdo_q;
        done_n    = 1'b0;
        fcnt_n    = frame_cnt;
        if (state_q != IDLE && cs_rise) begin
            // Abort wins over a coincident SCLK edge, including the completing one.
            state_n = IDLE;
            sdo_n   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sdo_n = 1'b0;
                    if (cs_fall && armed_q) begin
                        state_n   = LEAD;
                        shreg_n   = capture_val;
                        bit_cnt_n = 8'd0;
                    end
                end
                LEAD: begin
                    if (sclk_fall) begin
                        bit_cnt_n = cnt_inc;
                        if (cnt_inc == LZ_CNT) begin
                            sdo_n   = shreg_q[11];
                            state_n = DATA;
                        end
                    end
                end
                DATA: begin
                    if (sclk_fall) begin
                        bit_cnt_n = cnt_inc;
                        if (cnt_inc == LAST_CNT) begin
                            sdo_n   = 1'b0;
                            done_n  = 1'b1;
                            fcnt_n  = frame_cnt + 16'd1;
                            state_n = TRAIL;
                        end else begin
                            shreg_n = {shreg_q[10:0], 1'b0};
                            sdo_n   = shreg_q[10];
                        end
                    end
                end
                TRAIL: begin
                    sdo_n = 1'b0;
                    if (sclk_fall) begin
                        bit_cnt_n = cnt_inc;
                    end
                end
                default: begin
                    state_n = IDLE;
                    sdo_n   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= 12'd0;
            bit_cnt_q  <= 8'd0;
            sdo_q      <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            state_q    <= state_n;
            shreg_q    <= shreg_n;
            bit_cnt_q  <= bit_cnt_n;
            sdo_q      <= sdo_n;
            frame_done <= done_n;
            frame_cnt  <= fcnt_n;
        end
    end

    assign SDO       = sdo_q;
    assign SDO_OE    = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ads7883_emulator.sv
// Self-checking bench for ads7883_emulator: table of frames plus hand-written reset, wrap and idle sequences.
// Expected SDO bits go through a scoreboard queue; build with ADC_EMU_RAMP_EN to check the ramp variant.
module tb_ads7883_emulator;

  localparam int SYNC = 2;
  localparam int LZ   = 2;
  localparam int HALF = 8;  // clk cycles per SCLK half period

  logic        clk = 1'b0;
  logic        rst;
  logic        CONVST;
  logic        SCLK;
  logic [11:0] sample_in;
  logic        SDO;
  logic        SDO_OE;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic [1:0]  state_dbg;

  ads7883_emulator #(.SYNC_STAGES(SYNC), .LEAD_ZEROS(LZ)) dut (
    .clk        (clk),
    .rst        (rst),
    .CONVST     (CONVST),
    .SCLK       (SCLK),
    .sample_in  (sample_in),
    .SDO        (SDO),
    .SDO_OE     (SDO_OE),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          done_pulses = 0;
  logic [0:0]  exp_q[$];
  logic [15:0] exp_cnt = 16'd0;
  logic [11:0] ramp_m = 12'd0;

  always @(negedge clk) begin
    if (frame_done) done_pulses++;
  end

  typedef struct {
    logic [11:0] sample;
    logic [11:0] mid;
    int          edges;
    logic        coincident;
    logic [11:0] exp_word;
    int          exp_done;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_pulse();
    SCLK = 1'b0;
    wait_clks(HALF);
    SCLK = 1'b1;
    wait_clks(HALF);
  endtask

  // driver: one frame from CONVST fall to CONVST rise
  task automatic run_frame(input vec_t v);
    logic [11:0] word;
    int          done0;
    logic        bit_exp;
    int          idx;
`ifdef ADC_EMU_RAMP_EN
    word = ramp_m;
`else
    word = v.exp_word;
`endif
    sample_in = v.sample;
    CONVST = 1'b0;
    if (v.coincident) SCLK = 1'b0;
    wait_clks(HALF);
    if (v.coincident) begin
      SCLK = 1'b1;
      wait_clks(HALF);
    end
    check("oe_active", SDO_OE, 1);
    done0 = done_pulses;
    // SDO as seen by the driver just before each SCLK falling edge
    for (int i = 1; i <= v.edges; i++) begin
      if (i <= LZ || i > LZ + 12) begin
        bit_exp = 1'b0;
      end else begin
        idx = 12 + LZ - i;
        bit_exp = word[idx];
      end
      exp_q.push_back(bit_exp);
    end
    for (int i = 1; i <= v.edges; i++) begin
      check("sdo_bit", SDO, exp_q.pop_front());
      if (i == v.edges / 2) sample_in = v.mid;
      sclk_pulse();
    end
    CONVST = 1'b1;
    wait_clks(SYNC + 2);
    check("sdo_after_end", SDO, 0);
    check("oe_after_end", SDO_OE, 0);
    check("frame_done_pulses", done_pulses - done0, v.exp_done);
    if (v.exp_done != 0) begin
      exp_cnt = exp_cnt + 16'd1;
      ramp_m  = ramp_m + 12'd1;
    end
    check("frame_cnt", frame_cnt, exp_cnt);
    wait_clks(HALF);
  endtask

  initial begin
    tbl[0] = '{12'hA5C, 12'hA5C, 16, 1'b0, 12'hA5C, 1};
    tbl[1] = '{12'h3C7, 12'h3C7,  6, 1'b0, 12'h3C7, 0};
    tbl[2] = '{12'hFFF, 12'h000, 16, 1'b0, 12'hFFF, 1};
    tbl[3] = '{12'h000, 12'hFFF, 16, 1'b0, 12'h000, 1};
    tbl[4] = '{12'h801, 12'h801, 14, 1'b0, 12'h801, 1};
    tbl[5] = '{12'h5A5, 12'h5A5, 13, 1'b0, 12'h5A5, 0};
    tbl[6] = '{12'h6B3, 12'h6B3, 20, 1'b0, 12'h6B3, 1};
    tbl[7] = '{12'h9E1, 12'h9E1, 16, 1'b1, 12'h9E1, 1};

    rst = 1'b1;
    CONVST = 1'b1;
    SCLK = 1'b1;
    sample_in = 12'd0;
    wait_clks(3);
    check("rst_sdo", SDO, 0);
    check("rst_oe", SDO_OE, 0);
    check("rst_done", frame_done, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;
    wait_clks(10);

    // SCLK activity while idle must not start anything
    for (int i = 0; i < 3; i++) sclk_pulse();
    check("idle_oe", SDO_OE, 0);
    check("idle_sdo", SDO, 0);
    check("idle_cnt", frame_cnt, exp_cnt);

    for (int t = 0; t < 8; t++) run_frame(tbl[t]);

    // frame counter wrap
    force dut.frame_cnt = 16'hFFFF;
    wait_clks(2);
    release dut.frame_cnt;
    wait_clks(1);
    exp_cnt = 16'hFFFF;
    check("preset_cnt", frame_cnt, 16'hFFFF);
    run_frame(tbl[0]);

    // reset in the middle of a frame, with CONVST still low afterwards
    sample_in = 12'h3A6;
    CONVST = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < 5; i++) sclk_pulse();
    check("midframe_oe", SDO_OE, 1);
    rst = 1'b1;
    wait_clks(2);
    check("mid_rst_sdo", SDO, 0);
    check("mid_rst_oe", SDO_OE, 0);
    check("mid_rst_done", frame_done, 0);
    check("mid_rst_cnt", frame_cnt, 0);
    exp_cnt = 16'd0;
    ramp_m = 12'd0;
    rst = 1'b0;
    begin
      int done0;
      done0 = done_pulses;
      wait_clks(10);
      for (int i = 0; i < 4; i++) sclk_pulse();
      check("low_after_rst_oe", SDO_OE, 0);
      check("low_after_rst_done", done_pulses - done0, 0);
    end
    CONVST = 1'b1;
    wait_clks(HALF);
    run_frame(tbl[0]);

    check("scoreboard_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
